// File: rtl/data_to_segments.sv
// -----------------------------------------------------------------------------
// data_to_segments
//
// Converts a binary value into decimal seven-segment patterns. The value is
// made into a sign plus magnitude, the magnitude goes through an iterative
// double-dabble (one bit per clock), and the BCD result is encoded into
// registered segment patterns with leading-zero blanking and a minus sign.
//
// Parameters
//   Size      width of Data
//   Signed    "Yes": Data is two's complement; "No": Data is a magnitude and
//             SigneBit carries the sign
//   Digits    number of decimal digits shown; must satisfy 10**Digits > 2**Size
//   ActiveLow 1: a lit segment is driven low
//
// Ports
//   Clock     system clock, rising edge
//   nReset    asynchronous active-low reset
//   Data      value to display (Size bits)
//   SigneBit  sign flag, only meaningful when Signed == "No"
//   Segments  7*Digits bits, digit k at [7k+6:7k], k=0 least significant,
//             each digit ordered {g,f,e,d,c,b,a}
//   SignSeg   sign digit {g,f,e,d,c,b,a}; only segment g is ever used
//   Busy      high from the capture edge until the outputs are updated
//
// Handshake: there is none. Data/SigneBit are sampled whenever the converter
// is idle; a change while Busy is high is picked up on the first idle edge
// after the conversion in flight finishes, and intermediate values may be
// skipped.
// -----------------------------------------------------------------------------
module data_to_segments #(
  parameter int    Size      = 5,
  parameter string Signed    = "No",
  parameter int    Digits    = 2,
  parameter int    ActiveLow = 1
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic [Size-1:0]       Data,
  input  logic                  SigneBit,
  output logic [7*Digits-1:0]   Segments,
  output logic [6:0]            SignSeg,
  output logic                  Busy
);

  // The decimal range must cover every magnitude, including 2**(Size-1)
  // for the most negative signed value.
  if ((10 ** Digits) <= (2 ** Size)) begin : g_range_check
    $error("data_to_segments: Digits too small for Size");
  end

  localparam bit        IS_SIGNED = (Signed == "Yes");
  localparam int        BW        = 4 * Digits;
  localparam int        CW        = $clog2(Size + 1);
  localparam logic [6:0] BLANK7   = (ActiveLow != 0) ? 7'h7F : 7'h00;
  localparam logic [Size-1:0] ONE = Size'(1);

  // The state register names the phase executed on the most recent clock
  // edge: the capture edge leaves LOAD, each shift edge leaves SHIFT and the
  // output edge leaves UPDATE. IDLE and UPDATE both mean "free to start".
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, UPDATE} state_t;

  state_t          state;
  logic [Size-1:0] data_q;
  logic            sign_q;
  logic            refresh;
  logic [Size-1:0] mag_q;
  logic            neg_q;
  logic            nz_q;
  logic [BW-1:0]   bcd_q;
  logic [CW-1:0]   cnt;

  logic [Size-1:0]     mag_in;
  logic                neg_in;
  logic                go;
  logic [BW-1:0]       bcd_adj;
  logic [7*Digits-1:0] seg_next;
  logic [6:0]          sign_next;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] lit);
    polarity = (ActiveLow != 0) ? ~lit : lit;
  endfunction

  // Sign/magnitude split of the live input, used on the capture edge.
  // For the most negative signed value the negation wraps to 2**(Size-1),
  // which is exactly the magnitude wanted when read as unsigned.
  always_comb begin
    neg_in = SigneBit;
    mag_in = Data;
    if (IS_SIGNED) begin
      neg_in = Data[Size-1];
      mag_in = Data[Size-1] ? (~Data + ONE) : Data;
    end
  end

  assign go = refresh || (Data != data_q) || (SigneBit != sign_q);

  // Double-dabble correction: any nibble of 5 or more gets 3 added before
  // the shift so that it carries correctly into the next decimal digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < Digits; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Segment encoding with leading-zero blanking: scanning from the top
  // digit down, digits stay blank until the first nonzero one; digit 0 is
  // always shown.
  always_comb begin
    logic       seen;
    logic [3:0] nib;
    logic [6:0] lit;
    seen     = 1'b0;
    nib      = 4'd0;
    lit      = 7'h00;
    seg_next = '0;
    for (int k = Digits - 1; k >= 0; k--) begin
      nib = bcd_q[4*k +: 4];
      if ((nib != 4'd0) || (k == 0)) begin
        seen = 1'b1;
      end
      lit = seen ? seg7(nib) : 7'h00;
      seg_next[7*k +: 7] = polarity(lit);
    end
    sign_next = polarity((neg_q && nz_q) ? 7'h40 : 7'h00);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Segments <= {Digits{BLANK7}};
      SignSeg  <= BLANK7;
      data_q   <= '0;
      sign_q   <= 1'b0;
      refresh  <= 1'b1;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      nz_q     <= 1'b0;
      bcd_q    <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        LOAD, SHIFT: begin
          if (cnt == CW'(Size)) begin
            Segments <= seg_next;
            SignSeg  <= sign_next;
            Busy     <= 1'b0;
            state    <= UPDATE;
          end else begin
            bcd_q <= {bcd_adj[BW-2:0], mag_q[Size-1]};
            mag_q <= mag_q << 1;
            cnt   <= cnt + CW'(1);
            state <= SHIFT;
          end
        end
        default: begin
          // IDLE or UPDATE: look for a new pair (or a pending refresh).
          if (go) begin
            data_q  <= Data;
            sign_q  <= SigneBit;
            mag_q   <= mag_in;
            neg_q   <= neg_in;
            nz_q    <= (mag_in != '0);
            bcd_q   <= '0;
            cnt     <= '0;
            refresh <= 1'b0;
            Busy    <= 1'b1;
            state   <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_to_segments.sv
// -----------------------------------------------------------------------------
// tb_data_to_segments
//
// Directed bench for data_to_segments with Size=5, Digits=2, ActiveLow=1.
// Two instances: one unsigned (SigneBit carries the sign) and one signed.
// All expected patterns are hand-computed active-low gfedcba constants.
// -----------------------------------------------------------------------------
module tb_data_to_segments;

  logic        clk;
  logic        rst_n;
  logic [4:0]  data_u;
  logic        sb_u;
  logic [13:0] seg_u;
  logic [6:0]  sign_u;
  logic        busy_u;
  logic [4:0]  data_s;
  logic [13:0] seg_s;
  logic [6:0]  sign_s;
  logic        busy_s;

  int n_checks;
  int n_errors;
  int busy_u_cnt;
  int busy_s_cnt;

  data_to_segments #(.Size(5), .Signed("No"), .Digits(2), .ActiveLow(1)) u_dut_u (
    .Clock(clk), .nReset(rst_n), .Data(data_u), .SigneBit(sb_u),
    .Segments(seg_u), .SignSeg(sign_u), .Busy(busy_u)
  );

  data_to_segments #(.Size(5), .Signed("Yes"), .Digits(2), .ActiveLow(1)) u_dut_s (
    .Clock(clk), .nReset(rst_n), .Data(data_s), .SigneBit(1'b1),
    .Segments(seg_s), .SignSeg(sign_s), .Busy(busy_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one rising edge, then sample 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // a full conversion: capture edge, 5 shift edges, update edge
  task automatic run_conv();
    busy_u_cnt = 0;
    busy_s_cnt = 0;
    repeat (7) begin
      step();
      if (busy_u) busy_u_cnt++;
      if (busy_s) busy_s_cnt++;
    end
  endtask

  initial begin
    logic saw_nine;
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    data_u = 5'd23;
    sb_u   = 1'b0;
    data_s = 5'b10000;

    // reset state
    repeat (3) step();
    check("rst_seg_u",  32'(seg_u),  32'h3FFF);
    check("rst_sign_u", 32'(sign_u), 32'h7F);
    check("rst_busy_u", 32'(busy_u), 32'h0);
    check("rst_seg_s",  32'(seg_s),  32'h3FFF);
    check("rst_sign_s", 32'(sign_s), 32'h7F);
    check("rst_busy_s", 32'(busy_s), 32'h0);

    // release: first edge loads without any input change
    @(negedge clk);
    rst_n = 1'b1;
    busy_u_cnt = 0;
    busy_s_cnt = 0;
    repeat (6) begin
      step();
      if (busy_u) busy_u_cnt++;
      if (busy_s) busy_s_cnt++;
    end
    check("no_early_update", 32'(seg_u), 32'h3FFF);
    step();
    check("busy_len_u", 32'(busy_u_cnt), 32'd6);
    check("busy_len_s", 32'(busy_s_cnt), 32'd6);
    check("busy_done_u", 32'(busy_u), 32'h0);
    check("seg_23",   32'(seg_u),  32'({7'h24, 7'h30}));
    check("sign_23",  32'(sign_u), 32'h7F);
    check("seg_m16",  32'(seg_s),  32'({7'h79, 7'h02}));
    check("sign_m16", 32'(sign_s), 32'h3F);

    // unsigned directed vectors
    data_u = 5'd7;
    run_conv();
    check("seg_7",  32'(seg_u),  32'({7'h7F, 7'h78}));
    check("sign_7", 32'(sign_u), 32'h7F);

    data_u = 5'd0; sb_u = 1'b1;
    run_conv();
    check("seg_0neg",  32'(seg_u),  32'({7'h7F, 7'h40}));
    check("sign_0neg", 32'(sign_u), 32'h7F);

    data_u = 5'd19;
    run_conv();
    check("seg_m19",  32'(seg_u),  32'({7'h79, 7'h10}));
    check("sign_m19", 32'(sign_u), 32'h3F);
    check("busy_len_19", 32'(busy_u_cnt), 32'd6);

    // no input change: stays idle
    repeat (3) step();
    check("idle_busy", 32'(busy_u), 32'h0);
    check("idle_seg",  32'(seg_u),  32'({7'h79, 7'h10}));

    // signed directed vectors
    data_s = 5'b01111;
    run_conv();
    check("seg_p15",  32'(seg_s),  32'({7'h79, 7'h12}));
    check("sign_p15", 32'(sign_s), 32'h7F);

    data_s = 5'b11101;
    run_conv();
    check("seg_m3",  32'(seg_s),  32'({7'h7F, 7'h30}));
    check("sign_m3", 32'(sign_s), 32'h3F);

    data_s = 5'b11111;
    run_conv();
    check("seg_m1",  32'(seg_s),  32'({7'h7F, 7'h79}));
    check("sign_m1", 32'(sign_s), 32'h3F);

    data_s = 5'b00000;
    run_conv();
    check("seg_s0",  32'(seg_s),  32'({7'h7F, 7'h40}));
    check("sign_s0", 32'(sign_s), 32'h7F);

    // input stepping during a conversion: 3 shown, 9 skipped, then 12
    saw_nine = 1'b0;
    data_u = 5'd3; sb_u = 1'b0;
    step();
    step();
    data_u = 5'd9;
    step();
    data_u = 5'd12;
    repeat (4) begin
      step();
      if (seg_u == {7'h7F, 7'h10}) saw_nine = 1'b1;
    end
    check("seg_3",  32'(seg_u), 32'({7'h7F, 7'h30}));
    check("busy_3", 32'(busy_u), 32'h0);
    step();
    check("reload_busy", 32'(busy_u), 32'h1);
    repeat (6) begin
      step();
      if (seg_u == {7'h7F, 7'h10}) saw_nine = 1'b1;
    end
    check("seg_12",   32'(seg_u), 32'({7'h79, 7'h24}));
    check("never_9",  32'(saw_nine), 32'h0);

    // reset in the middle of SHIFT
    data_u = 5'd5;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_seg",  32'(seg_u),  32'h3FFF);
    check("midrst_sign", 32'(sign_u), 32'h7F);
    check("midrst_busy", 32'(busy_u), 32'h0);
    data_u = 5'd31;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv();
    check("busy_len_31", 32'(busy_u_cnt), 32'd6);
    check("seg_31",  32'(seg_u),  32'({7'h30, 7'h79}));
    check("sign_31", 32'(sign_u), 32'h7F);
    check("busy_31", 32'(busy_u), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
